// File: rtl/rn_axis_pkt_sink.sv
// rtl/rn_axis_pkt_sink.sv - AXI4-Stream packet sink with backpressure, reassembly checks and statistics
module rn_axis_pkt_sink #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = 64,
   parameter int USER_SIZE_WIDTH = 16,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       axis_clk,
   input  logic                       axis_rstn,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   input  logic [USER_SIZE_WIDTH-1:0] s_axis_tuser_size,
   output logic                       s_axis_tready,
   input  logic [15:0]                bp_mask,
   input  logic [CNT_WIDTH-1:0]       expected_pkts,
   output logic                       pkt_done,
   output logic [USER_SIZE_WIDTH-1:0] pkt_len,
   output logic [CNT_WIDTH-1:0]       pkt_cnt,
   output logic [CNT_WIDTH-1:0]       byte_cnt,
   output logic [CNT_WIDTH-1:0]       err_cnt,
   output logic                       err_keep,
   output logic                       err_size,
   output logic                       all_received
);

   localparam int PC_W  = $clog2(AXIS_KEEP_WIDTH + 1);
   localparam int ACC_W = USER_SIZE_WIDTH + 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   state_t                     state_q;
   logic [3:0]                 phase_q;
   logic                       tready_q;
   logic [USER_SIZE_WIDTH-1:0] size_q;
   logic [ACC_W-1:0]           acc_q;
   logic                       perr_q;
   logic                       pkt_done_q;
   logic [USER_SIZE_WIDTH-1:0] pkt_len_q;
   logic [CNT_WIDTH-1:0]       pkt_cnt_q;
   logic [CNT_WIDTH-1:0]       byte_cnt_q;
   logic [CNT_WIDTH-1:0]       err_cnt_q;
   logic                       err_keep_q;
   logic                       err_size_q;

   // ------------------------------------------------------------------
   // Per-beat combinational evaluation
   // ------------------------------------------------------------------
   logic                       beat_acc;
   logic                       first_beat;
   logic [PC_W-1:0]            beat_ones;
   logic [AXIS_KEEP_WIDTH-1:0] keep_inc;
   logic                       last_keep_ok;
   logic                       keep_bad;
   logic [ACC_W-1:0]           acc_base;
   logic [ACC_W:0]             acc_sum;
   logic                       acc_ovf;
   logic [ACC_W-1:0]           acc_d;
   logic [USER_SIZE_WIDTH-1:0] ref_size;
   logic                       size_chg;
   logic                       len_bad;
   logic                       perr_d;
   logic [USER_SIZE_WIDTH-1:0] pkt_len_d;

   // Payload is never inspected; fold it so it is visibly consumed.
   logic unused_tdata;
   assign unused_tdata = ^s_axis_tdata;

   assign beat_acc   = s_axis_tvalid && tready_q;
   assign first_beat = (state_q == ST_IDLE);

   // Number of valid bytes in the current beat.
   always_comb begin
      beat_ones = '0;
      for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
         beat_ones = beat_ones + PC_W'(s_axis_tkeep[i]);
      end
   end

   // A mask of the form 2^n-1 has no bit in common with itself plus one;
   // all ones wraps to zero and is therefore also accepted.
   assign keep_inc     = s_axis_tkeep + AXIS_KEEP_WIDTH'(1);
   assign last_keep_ok = (s_axis_tkeep != '0) && ((s_axis_tkeep & keep_inc) == '0);

   // Keep legality, size consistency and saturating byte accumulation.
   always_comb begin
      keep_bad  = s_axis_tlast ? !last_keep_ok : (s_axis_tkeep != '1);
      acc_base  = first_beat ? '0 : acc_q;
      acc_sum   = {1'b0, acc_base} + (ACC_W + 1)'(beat_ones);
      acc_ovf   = acc_sum[ACC_W];
      acc_d     = acc_ovf ? '1 : acc_sum[ACC_W-1:0];
      ref_size  = first_beat ? s_axis_tuser_size : size_q;
      size_chg  = !first_beat && (s_axis_tuser_size != size_q);
      len_bad   = s_axis_tlast && (acc_d != {1'b0, ref_size});
      perr_d    = (!first_beat && perr_q) || keep_bad || size_chg || acc_ovf || len_bad;
      // The accumulator is one bit wider than pkt_len; clamp instead of
      // letting an oversized packet alias to a small length.
      pkt_len_d = acc_d[ACC_W-1] ? '1 : acc_d[USER_SIZE_WIDTH-1:0];
   end

   // ------------------------------------------------------------------
   // Backpressure pattern: free-running phase selects a bit of bp_mask.
   // ------------------------------------------------------------------
   // Phase counter and registered ready.
   always_ff @(posedge axis_clk) begin
      if (!axis_rstn) begin
         phase_q  <= 4'd0;
         tready_q <= 1'b0;
      end else begin
         phase_q  <= phase_q + 4'd1;
         tready_q <= ~bp_mask[phase_q];
      end
   end

   // ------------------------------------------------------------------
   // Packet reassembly FSM with registered result and statistics outputs.
   // ------------------------------------------------------------------
   // Packet state, per-packet checks and cumulative counters.
   always_ff @(posedge axis_clk) begin
      if (!axis_rstn) begin
         state_q    <= ST_IDLE;
         size_q     <= '0;
         acc_q      <= '0;
         perr_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         pkt_len_q  <= '0;
         pkt_cnt_q  <= '0;
         byte_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_keep_q <= 1'b0;
         err_size_q <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         if (beat_acc) begin
            byte_cnt_q <= byte_cnt_q + CNT_WIDTH'(beat_ones);
            if (first_beat) begin
               size_q <= s_axis_tuser_size;
            end
            if (keep_bad) begin
               err_keep_q <= 1'b1;
            end
            if (size_chg || acc_ovf || len_bad) begin
               err_size_q <= 1'b1;
            end
            case (state_q)
               ST_IDLE, ST_IN_PKT: begin
                  if (s_axis_tlast) begin
                     state_q    <= ST_IDLE;
                     acc_q      <= '0;
                     perr_q     <= 1'b0;
                     pkt_done_q <= 1'b1;
                     pkt_len_q  <= pkt_len_d;
                     pkt_cnt_q  <= pkt_cnt_q + CNT_WIDTH'(1);
                     if (perr_d && (err_cnt_q != '1)) begin
                        err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
                     end
                  end else begin
                     state_q <= ST_IN_PKT;
                     acc_q   <= acc_d;
                     perr_q  <= perr_d;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign s_axis_tready = tready_q;
   assign pkt_done      = pkt_done_q;
   assign pkt_len       = pkt_len_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign byte_cnt      = byte_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign err_keep      = err_keep_q;
   assign err_size      = err_size_q;
   assign all_received  = (pkt_cnt_q == expected_pkts) && (expected_pkts != '0);

endmodule

// File: tb/tb_rn_axis_pkt_sink.sv
// tb/tb_rn_axis_pkt_sink.sv - randomized self-checking bench for rn_axis_pkt_sink
module tb_rn_axis_pkt_sink;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int UW = 16;
   localparam int CW = 32;

   logic          axis_clk = 1'b0;
   logic          axis_rstn;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic [UW-1:0] s_axis_tuser_size;
   logic          s_axis_tready;
   logic [15:0]   bp_mask;
   logic [CW-1:0] expected_pkts;
   logic          pkt_done;
   logic [UW-1:0] pkt_len;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] byte_cnt;
   logic [CW-1:0] err_cnt;
   logic          err_keep;
   logic          err_size;
   logic          all_received;

   always #5 axis_clk = ~axis_clk;

   rn_axis_pkt_sink #(
      .AXIS_DATA_WIDTH(DW),
      .AXIS_KEEP_WIDTH(KW),
      .USER_SIZE_WIDTH(UW),
      .CNT_WIDTH(CW)
   ) dut (
      .axis_clk(axis_clk),
      .axis_rstn(axis_rstn),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser_size(s_axis_tuser_size),
      .s_axis_tready(s_axis_tready),
      .bp_mask(bp_mask),
      .expected_pkts(expected_pkts),
      .pkt_done(pkt_done),
      .pkt_len(pkt_len),
      .pkt_cnt(pkt_cnt),
      .byte_cnt(byte_cnt),
      .err_cnt(err_cnt),
      .err_keep(err_keep),
      .err_size(err_size),
      .all_received(all_received)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Ready reference: one cycle after reset release the pattern starts at phase 0.
   logic [3:0] m_phase = 4'd0;
   logic       m_rdy   = 1'b0;
   bit         mon_en  = 1'b0;

   always @(posedge axis_clk) begin
      if (!axis_rstn) begin
         m_phase <= 4'd0;
         m_rdy   <= 1'b0;
      end else begin
         m_phase <= m_phase + 4'd1;
         m_rdy   <= ~bp_mask[m_phase];
      end
   end

   always @(negedge axis_clk) begin
      if (mon_en) check("tready", s_axis_tready, m_rdy);
   end

   // Statistics reference.
   logic [CW-1:0] m_pkt, m_bytes, m_err;
   logic [UW-1:0] m_len;
   bit            m_ek, m_es;

   logic [KW-1:0] pk_keep[$];
   logic [UW-1:0] pk_size[$];

   function automatic bit legal_last(input logic [KW-1:0] k);
      logic [KW:0] m;
      int c;
      c = $countones(k);
      m = ({{KW{1'b0}}, 1'b1} << c) - 1;
      return (c != 0) && ({1'b0, k} == m);
   endfunction

   task automatic model_clear();
      m_pkt = '0; m_bytes = '0; m_err = '0; m_len = '0; m_ek = 0; m_es = 0;
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_pkt_len"},  pkt_len,  m_len);
      check({tag, "_pkt_cnt"},  pkt_cnt,  m_pkt);
      check({tag, "_byte_cnt"}, byte_cnt, m_bytes);
      check({tag, "_err_cnt"},  err_cnt,  m_err);
      check({tag, "_err_keep"}, err_keep, m_ek);
      check({tag, "_err_size"}, err_size, m_es);
      check({tag, "_all_rx"},   all_received, (m_pkt == expected_pkts) && (expected_pkts != 0));
   endtask

   task automatic reset_dut(input int cycles);
      axis_rstn     = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (cycles) @(posedge axis_clk);
      #1 axis_rstn = 1'b1;
      model_clear();
      check("rst_tready",   s_axis_tready, 0);
      check("rst_pkt_done", pkt_done, 0);
      check_stats("rst");
   endtask

   // Drive one beat and hold it until the sink accepts it (bounded).
   task automatic send_beat(input logic [KW-1:0] k, input logic [UW-1:0] sz, input bit last,
                            output bit ok);
      for (int w = 0; w < DW / 32; w++) s_axis_tdata[w*32 +: 32] = $urandom;
      s_axis_tkeep      = k;
      s_axis_tuser_size = sz;
      s_axis_tlast      = last;
      s_axis_tvalid     = 1'b1;
      ok = 0;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge axis_clk);
         if (s_axis_tready === 1'b1) ok = 1;
         @(posedge axis_clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   // Send the packet in pk_keep/pk_size and check results against the rules.
   task automatic send_pkt(input string tag, input int gap);
      int      n;
      longint  bytes;
      bit      ek, es, ok;
      n = pk_keep.size();
      bytes = 0; ek = 0; es = 0;
      for (int i = 0; i < n; i++) begin
         bytes += $countones(pk_keep[i]);
         if (pk_size[i] != pk_size[0]) es = 1;
         if (i < n - 1) begin
            if (pk_keep[i] != {KW{1'b1}}) ek = 1;
         end else if (!legal_last(pk_keep[i])) ek = 1;
      end
      if (bytes != pk_size[0]) es = 1;
      for (int i = 0; i < n; i++) begin
         send_beat(pk_keep[i], pk_size[i], i == n - 1, ok);
         m_bytes += CW'($countones(pk_keep[i]));
         if (i < n - 1) begin
            check({tag, "_mid_done"}, pkt_done, 0);
            check({tag, "_mid_bytes"}, byte_cnt, m_bytes);
         end
      end
      m_pkt += 1;
      m_len  = UW'(bytes);
      if (ek || es) m_err += 1;
      m_ek |= ek;
      m_es |= es;
      check({tag, "_done"}, pkt_done, 1);
      check_stats(tag);
      if (gap > 0) begin
         @(posedge axis_clk); #1;
         check({tag, "_done_pulse"}, pkt_done, 0);
         repeat (gap - 1) @(posedge axis_clk);
         #1;
      end
   endtask

   task automatic build_pkt(input int bytes);
      int rem, take;
      pk_keep.delete();
      pk_size.delete();
      rem = bytes;
      while (rem > 0) begin
         take = (rem >= KW) ? KW : rem;
         pk_keep.push_back((take == KW) ? {KW{1'b1}} : (({{(KW-1){1'b0}}, 1'b1} << take) - 1));
         pk_size.push_back(UW'(bytes));
         rem -= take;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int nr;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0; s_axis_tuser_size = '0;
      s_axis_tvalid = 0; bp_mask = 16'h0; expected_pkts = 1; axis_rstn = 0;
      model_clear();
      reset_dut(2);
      mon_en = 1'b1;

      build_pkt(64);
      send_pkt("one_beat", 1);
      build_pkt(150);
      send_pkt("three_beat", 1);
      build_pkt(100);
      foreach (pk_size[i]) pk_size[i] = 16'd99;
      send_pkt("size_err", 2);
      pk_keep.delete(); pk_size.delete();
      pk_keep.push_back({KW{1'b1}}); pk_size.push_back(16'd8);
      pk_keep.push_back(64'h0F0F);   pk_size.push_back(16'd8);
      send_pkt("keep_err", 1);

      bp_mask = 16'hAAAA; expected_pkts = 10;
      reset_dut(1);
      for (int p = 0; p < 10; p++) begin
         build_pkt(128);
         send_pkt("bp", 0);
      end
      check("bp_final_pkt_cnt", pkt_cnt, 10);
      check("bp_final_bytes", byte_cnt, 1280);
      check("bp_final_all_rx", all_received, 1);

      bp_mask = 16'h0; expected_pkts = 1;
      send_beat({KW{1'b1}}, 16'd100, 1'b0, ok);
      reset_dut(1);
      build_pkt(64);
      send_pkt("post_rst", 1);

      nr = 40;
      expected_pkts = nr;
      reset_dut(2);
      for (int p = 0; p < nr; p++) begin
         logic [15:0] bp;
         bp = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
         bp[$urandom_range(0, 15)] = 1'b0;
         bp_mask = bp;
         build_pkt($urandom_range(1, 300));
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 3))
               0: pk_size[pk_size.size() - 1] = pk_size[0] + 16'd3;
               1: foreach (pk_size[i]) pk_size[i] = pk_size[i] - 16'd1;
               2: pk_keep[0][$urandom_range(0, KW - 1)] = 1'b0;
               default: pk_keep[pk_keep.size() - 1] = pk_keep[pk_keep.size() - 1] << 1;
            endcase
         end
         send_pkt("rand", $urandom_range(0, 2));
      end
      check("rand_all_rx", all_received, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rn_axis_pkt_sink.md
# rn_axis_pkt_sink

AXI4-Stream packet sink for the RecoNIC simulation environment. It is the receiving end of the stream that the stimulus driver produces, and it consumes the same beat format: data, keep, valid, last, plus a per-beat packet byte size on tuser. It applies a programmable backpressure pattern, reassembles beats into packets, checks keep-mask legality and the declared size against the bytes counted, and exposes per-packet and cumulative statistics plus a completion flag to the testbench top.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 512, stream data width in bits
- AXIS_KEEP_WIDTH, 64, keep width (bytes per beat)
- USER_SIZE_WIDTH, 16, width of tuser_size and pkt_len
- CNT_WIDTH, 32, width of statistics counters

Ports:
- axis_clk  in  1  sole clock
- axis_rstn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  AXIS_DATA_WIDTH  beat data (not checked)
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tuser_size  in  USER_SIZE_WIDTH  declared packet length in bytes
- s_axis_tready  out  1  sink ready (registered)
- bp_mask  in  16  backpressure pattern; bit i=1 stalls phase i
- expected_pkts  in  CNT_WIDTH  packets expected before all_received
- pkt_done  out  1  one-cycle pulse per completed packet
- pkt_len  out  USER_SIZE_WIDTH  bytes counted in last completed packet
- pkt_cnt  out  CNT_WIDTH  completed packets
- byte_cnt  out  CNT_WIDTH  accepted bytes (popcount of tkeep)
- err_cnt  out  CNT_WIDTH  packets with at least one error
- err_keep  out  1  sticky: illegal keep seen
- err_size  out  1  sticky: size mismatch or overflow seen
- all_received  out  1  pkt_cnt == expected_pkts and expected_pkts != 0

## Operation
- Beat accepted when s_axis_tvalid && s_axis_tready at posedge.
- States: IDLE (no packet open) and IN_PKT. An accepted beat with tlast=0 moves to or stays in IN_PKT. An accepted beat with tlast=1 returns to IDLE.
- First beat of a packet, accepted in IDLE, latches tuser_size. In IN_PKT, a tuser_size differing from the latched value sets the packet error and err_size.
- Per-beat byte count is the popcount of tkeep, added to a packet accumulator of USER_SIZE_WIDTH+1 bits. The accumulator saturates at its maximum; overflow sets the packet error and err_size.
- Keep rules:
  - A non-last beat must be all ones.
  - A last beat must be nonzero and contiguous from bit 0 (form 2^n-1).
  - A violation sets the packet error and err_keep.
- At tlast:
  - accumulated bytes != latched size sets the packet error and err_size;
  - pkt_cnt increments;
  - err_cnt increments once if the packet error is set, regardless of how many checks failed;
  - pkt_len is loaded with the accumulated byte count;
  - the accumulator and the packet error clear.
- byte_cnt adds the beat popcount on every accepted beat.
- Counter wrap rules: pkt_cnt and byte_cnt wrap modulo 2^CNT_WIDTH; err_cnt saturates at all ones.
- Backpressure: a 4-bit phase counter increments every cycle out of reset. s_axis_tready <= ~bp_mask[phase].

## Timing
- Reset, while axis_rstn=0 at posedge: every output, state, phase, and accumulator is 0, so s_axis_tready=0 and all_received=0.
- The first cycle after reset, s_axis_tready=0. The next cycle it equals ~bp_mask[0].
- pkt_done, pkt_len, pkt_cnt, err_cnt, err_keep, and err_size update at the posedge that accepts the tlast beat, so they are visible in the following cycle. pkt_done is high for exactly one cycle.
- all_received is combinational from registered pkt_cnt and from expected_pkts.
- Back-to-back packets with no idle cycle (tlast beat, then the next first beat) are supported at full rate with bp_mask=0.
- A beat presented while tready=0 is not accepted and has no effect.
- Reset mid-packet discards the open packet. Beats that arrive after reset are treated as a new packet.

## Test plan
- One beat, tkeep all ones, size 64, bp_mask=0 -> pkt_done pulse, pkt_len=64, pkt_cnt=1, byte_cnt=64, err_cnt=0.
- 150-byte packet as three beats with keep all-ones, all-ones, 0x3FFFFF and size 150 -> pkt_len=150, no error flags.
- 100-byte packet (keep all-ones, then 0xFFFFFFFFF) declared size 99 -> err_size=1, err_cnt=1, pkt_cnt=1, pkt_len=100.
- Last beat keep 0x0F0F with size 8 -> err_keep=1, err_size=1, err_cnt=1 (counted once).
- bp_mask=0xAAAA, expected_pkts=10, ten 128-byte packets -> tready alternates, pkt_cnt=10, byte_cnt=1280, all_received=1.
- Reset for one cycle after the first beat of a 2-beat packet, then a fresh 64-byte packet -> all counters zero after reset, then pkt_cnt=1, pkt_len=64, no errors.
